// File: rtl/spine_tile_switch_if.sv
// Port bundle for spine_tile_switch: NI and spine valid/ready channels plus FIFO status.
// The switch connects through the slave modport; its environment uses master.
interface spine_tile_switch_if #(
    parameter int DWIDTH     = 16,
    parameter int NUM_SPINES = 4
);
    localparam int GW = $clog2(NUM_SPINES + 1);

    logic [DWIDTH-1:0]            gpu_in_data;
    logic                         gpu_in_valid;
    logic                         gpu_in_ready;
    logic [DWIDTH-1:0]            gpu_out_data;
    logic                         gpu_out_valid;
    logic                         gpu_out_ready;
    logic [NUM_SPINES*DWIDTH-1:0] spine_in_data;
    logic [NUM_SPINES-1:0]        spine_in_valid;
    logic [NUM_SPINES-1:0]        spine_in_ready;
    logic [NUM_SPINES*DWIDTH-1:0] spine_out_data;
    logic [NUM_SPINES-1:0]        spine_out_valid;
    logic [NUM_SPINES-1:0]        spine_out_ready;
    logic [NUM_SPINES:0]          fifo_full;
    logic [NUM_SPINES:0]          fifo_empty;
    logic [GW-1:0]                current_grant;

    modport slave (
        input  gpu_in_data, gpu_in_valid, gpu_out_ready,
        input  spine_in_data, spine_in_valid, spine_out_ready,
        output gpu_in_ready, gpu_out_data, gpu_out_valid,
        output spine_in_ready, spine_out_data, spine_out_valid,
        output fifo_full, fifo_empty, current_grant
    );

    modport master (
        output gpu_in_data, gpu_in_valid, gpu_out_ready,
        output spine_in_data, spine_in_valid, spine_out_ready,
        input  gpu_in_ready, gpu_out_data, gpu_out_valid,
        input  spine_in_ready, spine_out_data, spine_out_valid,
        input  fifo_full, fifo_empty, current_grant
    );
endinterface

// File: rtl/spine_tile_switch.sv
// Tile switch between one GPU NI and NUM_SPINES spine links: buffered ingress, round-robin
// egress to the GPU, dest-indexed GPU-to-spine forwarding. SPINE_TILE_DROP_CNT_EN adds drop_count.
module spine_tile_switch #(
    parameter int                DWIDTH     = 16,
    parameter int                ADDR_W     = 6,
    parameter int                NUM_SPINES = 4,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-3:0] GROUP_ID   = 4'b0100,
    parameter int                ROUTER_ID  = 2
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    spine_tile_switch_if.slave  bus
`ifdef SPINE_TILE_DROP_CNT_EN
    ,
    output logic [15:0]         drop_count
`endif
);
    localparam int NP      = NUM_SPINES + 1;
    localparam int GPU_IDX = NUM_SPINES;
    localparam int GW      = $clog2(NP);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int SW      = $clog2(NUM_SPINES);

    localparam logic [1:0]        RID        = 2'(ROUTER_ID);
    localparam logic [ADDR_W-1:0] LOCAL_DEST = {GROUP_ID, RID};
    localparam logic [GW-1:0]     LAST_IDX   = GW'(NP - 1);
    localparam logic [CW-1:0]     FULL_CNT   = CW'(FIFO_DEPTH);

    logic [DWIDTH-1:0]     w_in_data [NP];
    logic [DWIDTH-1:0]     w_head    [NP];
    logic [NP-1:0]         w_in_valid;
    logic [NP-1:0]         w_push;
    logic [NP-1:0]         w_pop;
    logic [NP-1:0]         w_full;
    logic [NP-1:0]         w_empty;
    logic [NP-1:0]         w_local;
    logic [NUM_SPINES-1:0] w_drop;
    logic [NUM_SPINES-1:0] w_sout_valid;

    logic [GW-1:0]         w_win;
    logic                  w_found;
    int unsigned           w_idx;
    logic                  w_gpu_load;
    logic [DWIDTH-1:0]     w_gpu_head;
    logic [SW-1:0]         w_sel;
    logic                  w_fwd;

    logic [DWIDTH-1:0]     r_gpu_out_data;
    logic                  r_gpu_out_valid;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_rr_ptr;

    assign w_in_valid          = {bus.gpu_in_valid, bus.spine_in_valid};
    assign w_in_data[GPU_IDX]  = bus.gpu_in_data;

    for (genvar s = 0; s < NUM_SPINES; s++) begin : g_in
        assign w_in_data[s] = bus.spine_in_data[s*DWIDTH +: DWIDTH];
    end

    // Ingress FIFOs; ready is purely a function of occupancy.
    for (genvar g = 0; g < NP; g++) begin : g_fifo
        logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [PW-1:0]     r_wptr;
        logic [PW-1:0]     r_rptr;
        logic [CW-1:0]     r_cnt;

        assign w_full[g]  = (r_cnt == FULL_CNT);
        assign w_empty[g] = (r_cnt == '0);
        assign w_head[g]  = r_mem[r_rptr];
        assign w_push[g]  = w_in_valid[g] && !w_full[g];
        assign w_local[g] = !w_empty[g] && (w_head[g][DWIDTH-1 -: ADDR_W] == LOCAL_DEST);

        always_ff @(posedge ACLK) begin
            if (w_push[g]) begin
                r_mem[r_wptr] <= w_in_data[g];
            end
        end

        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop[g]) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_cnt <= r_cnt + CW'(w_push[g]) - CW'(w_pop[g]);
            end
        end
    end

    // Round-robin search over local heads, starting at the pointer.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned off = 0; off < NP; off++) begin
            w_idx = (32'(r_rr_ptr) + off) % NP;
            if (!w_found && w_local[w_idx]) begin
                w_win   = GW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_gpu_load = (!r_gpu_out_valid || bus.gpu_out_ready) && (|w_local);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_gpu_out_data  <= '0;
            r_gpu_out_valid <= 1'b0;
            r_grant         <= '0;
            r_rr_ptr        <= '0;
        end else if (w_gpu_load) begin
            r_gpu_out_data  <= w_head[w_win];
            r_gpu_out_valid <= 1'b1;
            r_grant         <= w_win;
            r_rr_ptr        <= (w_win == LAST_IDX) ? '0 : w_win + GW'(1);
        end else if (bus.gpu_out_ready) begin
            r_gpu_out_valid <= 1'b0;
        end
    end

    // Non-local GPU head goes to the spine addressed by the low dest bits, or waits.
    assign w_gpu_head = w_head[GPU_IDX];
    assign w_sel      = w_gpu_head[DWIDTH-ADDR_W +: SW];
    assign w_fwd      = !w_empty[GPU_IDX] && !w_local[GPU_IDX] &&
                        (!w_sout_valid[w_sel] || bus.spine_out_ready[w_sel]);

    assign w_pop[GPU_IDX] = w_fwd || (w_gpu_load && (w_win == GW'(GPU_IDX)));

    for (genvar s = 0; s < NUM_SPINES; s++) begin : g_spine
        logic [DWIDTH-1:0] r_data;
        logic              r_valid;

        assign w_drop[s] = !w_empty[s] && !w_local[s];
        assign w_pop[s]  = w_drop[s] || (w_gpu_load && (w_win == GW'(s)));

        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_fwd && (w_sel == SW'(s))) begin
                r_data  <= w_gpu_head;
                r_valid <= 1'b1;
            end else if (bus.spine_out_ready[s]) begin
                r_valid <= 1'b0;
            end
        end

        assign w_sout_valid[s]                      = r_valid;
        assign bus.spine_out_data[s*DWIDTH +: DWIDTH] = r_data;
    end

`ifdef SPINE_TILE_DROP_CNT_EN
    logic [15:0]   r_drop_cnt;
    logic [SW:0]   w_ndrop;
    logic [16:0]   w_dsum;

    always_comb begin
        w_ndrop = '0;
        for (int unsigned s = 0; s < NUM_SPINES; s++) begin
            w_ndrop = w_ndrop + (SW+1)'(w_drop[s]);
        end
        w_dsum = 17'(r_drop_cnt) + 17'(w_ndrop);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_dsum[16] ? '1 : w_dsum[15:0];
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    assign bus.gpu_in_ready    = !w_full[GPU_IDX];
    assign bus.spine_in_ready  = ~w_full[NUM_SPINES-1:0];
    assign bus.gpu_out_data    = r_gpu_out_data;
    assign bus.gpu_out_valid   = r_gpu_out_valid;
    assign bus.spine_out_valid = w_sout_valid;
    assign bus.fifo_full       = w_full;
    assign bus.fifo_empty      = w_empty;
    assign bus.current_grant   = r_grant;
endmodule

// File: tb/tb_spine_tile_switch.sv
// Directed and random bench for spine_tile_switch against a queue-based reference model.
module tb_spine_tile_switch;
    localparam int DW    = 16;
    localparam int NS    = 4;
    localparam int NP    = NS + 1;
    localparam int DEPTH = 4;
    localparam logic [5:0] LOCAL = 6'h12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    spine_tile_switch_if #(.DWIDTH(DW), .NUM_SPINES(NS)) bus ();

`ifdef SPINE_TILE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    spine_tile_switch #(
        .DWIDTH(DW), .ADDR_W(6), .NUM_SPINES(NS), .FIFO_DEPTH(DEPTH),
        .GROUP_ID(4'b0100), .ROUTER_ID(2)
    ) dut (
        .ACLK(clk),
        .ARESETn(rst_n),
        .bus(bus)
`ifdef SPINE_TILE_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one queue per ingress port, output slots, arbiter pointer.
    logic [15:0] mq [NP][$];
    bit          m_gov;
    logic [15:0] m_gout;
    int          m_grant;
    int          m_ptr;
    bit [NS-1:0] m_sov;
    logic [15:0] m_sout [NS];
    int          m_drops;

    function automatic bit is_local(input logic [15:0] f);
        return f[15:10] == LOCAL;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) mq[i].delete();
        m_gov = 0; m_gout = '0; m_grant = 0; m_ptr = 0; m_sov = '0; m_drops = 0;
        for (int s = 0; s < NS; s++) m_sout[s] = '0;
    endtask

    task automatic model_step();
        logic [15:0] hd [NP];
        logic [15:0] ind [NP];
        bit          ne [NP];
        bit          acc [NP];
        int          win;
        int          sel;
        for (int i = 0; i < NP; i++) begin
            ne[i]  = mq[i].size() > 0;
            hd[i]  = ne[i] ? mq[i][0] : '0;
            ind[i] = (i == NS) ? bus.gpu_in_data : bus.spine_in_data[i*DW +: DW];
            acc[i] = ((i == NS) ? bus.gpu_in_valid : bus.spine_in_valid[i]) && (mq[i].size() < DEPTH);
        end
        win = -1;
        for (int o = 0; o < NP; o++) begin
            int i;
            i = (m_ptr + o) % NP;
            if (win < 0 && ne[i] && is_local(hd[i])) win = i;
        end
        if ((!m_gov || bus.gpu_out_ready) && win >= 0) begin
            m_gout = hd[win]; m_gov = 1; m_grant = win; m_ptr = (win + 1) % NP;
            void'(mq[win].pop_front());
        end else if (bus.gpu_out_ready) begin
            m_gov = 0;
        end
        for (int k = 0; k < NS; k++) begin
            if (ne[k] && !is_local(hd[k])) begin
                void'(mq[k].pop_front());
                if (m_drops < 65535) m_drops++;
            end
        end
        for (int s = 0; s < NS; s++) if (bus.spine_out_ready[s]) m_sov[s] = 0;
        sel = int'(hd[NS][11:10]);
        if (ne[NS] && !is_local(hd[NS]) && !m_sov[sel]) begin
            m_sout[sel] = hd[NS]; m_sov[sel] = 1;
            void'(mq[NS].pop_front());
        end
        for (int i = 0; i < NP; i++) if (acc[i]) mq[i].push_back(ind[i]);
    endtask

    task automatic compare();
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("fifo_full%0d", i), 32'(bus.fifo_full[i]), 32'(mq[i].size() == DEPTH));
            chk($sformatf("fifo_empty%0d", i), 32'(bus.fifo_empty[i]), 32'(mq[i].size() == 0));
        end
        for (int k = 0; k < NS; k++)
            chk($sformatf("spine_in_ready%0d", k), 32'(bus.spine_in_ready[k]), 32'(mq[k].size() < DEPTH));
        chk("gpu_in_ready", 32'(bus.gpu_in_ready), 32'(mq[NS].size() < DEPTH));
        chk("gpu_out_valid", 32'(bus.gpu_out_valid), 32'(m_gov));
        if (m_gov) chk("gpu_out_data", 32'(bus.gpu_out_data), 32'(m_gout));
        chk("current_grant", 32'(bus.current_grant), 32'(m_grant));
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("spine_out_valid%0d", s), 32'(bus.spine_out_valid[s]), 32'(m_sov[s]));
            if (m_sov[s]) chk($sformatf("spine_out_data%0d", s), 32'(bus.spine_out_data[s*DW +: DW]), 32'(m_sout[s]));
        end
`ifdef SPINE_TILE_DROP_CNT_EN
        chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.gpu_in_valid = 1'b0; bus.gpu_in_data = '0; bus.gpu_out_ready = 1'b0;
        bus.spine_in_valid = '0; bus.spine_in_data = '0; bus.spine_out_ready = '0;
        #1;
        chk("rst_gpu_out_valid", 32'(bus.gpu_out_valid), 32'h0);
        chk("rst_spine_out_valid", 32'(bus.spine_out_valid), 32'h0);
        chk("rst_fifo_empty", 32'(bus.fifo_empty), 32'h1f);
        chk("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
        chk("rst_grant", 32'(bus.current_grant), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare();
    endtask

    function automatic logic [15:0] rand_flit();
        logic [15:0] f;
        f = 16'($urandom);
        case ($urandom_range(0, 2))
            0: f[15:10] = LOCAL;
            1: f[15:10] = 6'h13;
            default: ;
        endcase
        return f;
    endfunction

    initial begin
        int          accepted;
        int          got;
        bit          seen;
        bit          acc;

        do_reset();

        // Test 1: single local flit on spine 1, two-cycle latency.
        bus.gpu_out_ready = 1'b1; bus.spine_out_ready = '1;
        bus.spine_in_data[16 +: 16] = 16'h4855; bus.spine_in_valid = 4'b0010;
        cycle();
        bus.spine_in_valid = '0;
        chk("t1_valid_t1", 32'(bus.gpu_out_valid), 32'h0);
        cycle();
        chk("t1_valid_t2", 32'(bus.gpu_out_valid), 32'h1);
        chk("t1_data", 32'(bus.gpu_out_data), 32'h4855);
        chk("t1_grant", 32'(bus.current_grant), 32'h1);
        repeat (2) cycle();

        // Test 2: four simultaneous local flits leave in round-robin order.
        do_reset();
        bus.gpu_out_ready = 1'b1; bus.spine_out_ready = '1;
        for (int k = 0; k < NS; k++) bus.spine_in_data[k*16 +: 16] = 16'h4800 + 16'(k);
        bus.spine_in_valid = 4'hf;
        cycle();
        bus.spine_in_valid = '0;
        for (int k = 0; k < NS; k++) begin
            cycle();
            chk($sformatf("t2_valid%0d", k), 32'(bus.gpu_out_valid), 32'h1);
            chk($sformatf("t2_data%0d", k), 32'(bus.gpu_out_data), 32'h4800 + 32'(k));
        end
        cycle();
        chk("t2_idle", 32'(bus.gpu_out_valid), 32'h0);

        // Test 3: GPU to spine 3 with backpressure and a queued second flit.
        bus.spine_out_ready = 4'b0111;
        bus.gpu_in_data = 16'h4CAA; bus.gpu_in_valid = 1'b1;
        cycle();
        bus.gpu_in_data = 16'h4C01;
        cycle();
        bus.gpu_in_valid = 1'b0;
        chk("t3_sov3", 32'(bus.spine_out_valid[3]), 32'h1);
        chk("t3_sdata3", 32'(bus.spine_out_data[48 +: 16]), 32'h4CAA);
        repeat (3) cycle();
        chk("t3_hold", 32'(bus.spine_out_data[48 +: 16]), 32'h4CAA);
        chk("t3_queued", 32'(bus.fifo_empty[4]), 32'h0);
        bus.spine_out_ready = '1;
        cycle();
        chk("t3_second", 32'(bus.spine_out_data[48 +: 16]), 32'h4C01);
        cycle();
        chk("t3_drained", 32'(bus.spine_out_valid[3]), 32'h0);

        // Test 4: fill spine 2 with GPU egress stalled, then drain in order.
        bus.gpu_out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 20 && accepted < 5; c++) begin
            bus.spine_in_data[32 +: 16] = 16'h4900 + 16'(accepted);
            bus.spine_in_valid = 4'b0100;
            acc = bus.spine_in_ready[2];
            cycle();
            if (acc) accepted++;
        end
        bus.spine_in_valid = '0;
        chk("t4_accepted", 32'(accepted), 32'd5);
        chk("t4_full", 32'(bus.fifo_full[2]), 32'h1);
        chk("t4_ready", 32'(bus.spine_in_ready[2]), 32'h0);
        bus.gpu_out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (bus.gpu_out_valid) begin
                chk($sformatf("t4_order%0d", got), 32'(bus.gpu_out_data), 32'h4900 + 32'(got));
                got++;
            end
            cycle();
        end
        chk("t4_count", 32'(got), 32'd5);
        cycle();

        // Test 5: non-local spine flit is dropped.
        bus.spine_in_data[0 +: 16] = 16'h0001; bus.spine_in_valid = 4'b0001;
        cycle();
        bus.spine_in_valid = '0;
        seen = 0;
        repeat (4) begin
            cycle();
            if (bus.gpu_out_valid && bus.gpu_out_data == 16'h0001) seen = 1;
        end
        chk("t5_not_forwarded", 32'(seen), 32'h0);
`ifdef SPINE_TILE_DROP_CNT_EN
        chk("t5_drop_count", 32'(drop_count), 32'h1);
`endif

        // Test 6: reset with buffered flits and valid outputs.
        bus.gpu_out_ready = 1'b0; bus.spine_out_ready = '0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NS; k++) bus.spine_in_data[k*16 +: 16] = {LOCAL, 10'(c * 4 + k)};
            bus.spine_in_valid = 4'hf;
            bus.gpu_in_data = {6'h11, 10'(c)}; bus.gpu_in_valid = 1'b1;
            cycle();
        end
        do_reset();
        bus.gpu_out_ready = 1'b1; bus.spine_out_ready = '1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("t6_no_stale", 32'(bus.gpu_out_valid), 32'h0);
            chk("t6_no_stale_sp", 32'(bus.spine_out_valid), 32'h0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NS; k++) bus.spine_in_data[k*16 +: 16] = rand_flit();
            bus.spine_in_valid  = 4'($urandom);
            bus.gpu_in_data     = rand_flit();
            bus.gpu_in_valid    = 1'($urandom);
            bus.gpu_out_ready   = ($urandom_range(0, 9) < 7);
            bus.spine_out_ready = 4'($urandom) | 4'($urandom);
            cycle();
        end
        bus.spine_in_valid = '0; bus.gpu_in_valid = 1'b0;
        bus.gpu_out_ready = 1'b1; bus.spine_out_ready = '1;
        repeat (20) cycle();
        chk("final_empty", 32'(bus.fifo_empty), 32'h1f);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
